pll_supervisor: RTL and testbench
=================================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 8: length of the PLL reset pulse, in clk cycles.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 256: number of consecutive locked cycles required before release.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 4096: maximum wait for lock after a PLL reset.
REQ-004 Parameter MAX_RETRY, default 4: number of failed lock attempts before entering FAIL.
REQ-005 Parameter PHASE_SETTLE_CYCLES, default 16: wait after a psda change before acknowledging.
REQ-006 clk  in  1  free-running 3.579545 MHz PLL reference clock; all logic in this single domain.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 pll_lock  in  1  rPLL LOCK output, asynchronous to clk.
REQ-009 pll_reset  out  1  drives rPLL RESET.
REQ-010 psda  out  4  drives rPLL PSDA dynamic phase select.
REQ-011 phase_req  in  1  level request for a phase change; held until phase_ack.
REQ-012 phase_val  in  4  requested phase code; stable while phase_req is high.
REQ-013 phase_ack  out  1  one-cycle pulse: new phase applied and settled.
REQ-014 sys_reset  out  1  active-high reset for the PLL-clocked logic.
REQ-015 locked  out  1  high only in RUN and PHASE states.
REQ-016 fail  out  1  high only in FAIL state.
REQ-017 retry_cnt  out  3  number of failed attempts since the last RUN entry.

Function
REQ-018 pll_lock SHALL pass through a 2-flop synchronizer; all uses below refer to the synchronized value lk.
REQ-019 States SHALL be PLLRST, WAIT_LOCK, STABLE, RUN, PHASE, FAIL, held in a single state register with one shared down-counter.
REQ-020 PLLRST: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK: lk=1 goes to STABLE. If LOCK_TIMEOUT_CYCLES elapse with lk=0, retry_cnt increments and the block goes to PLLRST, or to FAIL if the incremented value equals MAX_RETRY.
REQ-022 STABLE: after LOCK_STABLE_CYCLES consecutive cycles of lk=1, go to RUN. Any lk=0 is treated as a timeout failure with the same retry rule as REQ-021.
REQ-023 RUN: sys_reset=0 and locked=1. retry_cnt clears to 0 on the cycle RUN is entered.
REQ-024 RUN with lk=0: go to PLLRST next cycle and assert sys_reset that cycle; retry_cnt is not incremented.
REQ-025 RUN with phase_req=1: latch phase_val into psda, then go to PHASE.
REQ-026 PHASE: hold psda for PHASE_SETTLE_CYCLES cycles, pulse phase_ack for 1 cycle, then return to RUN. The requester deasserts phase_req in the cycle after the ack; re-sampling of phase_req begins the cycle after the return to RUN.
REQ-027 lk=0 during PHASE SHALL take priority: go to PLLRST with no ack. psda keeps its new value, and the pending request is re-serviced after the next RUN entry.
REQ-028 sys_reset SHALL be 1 in every state except RUN and PHASE; it deasserts on the first RUN cycle.
REQ-029 FAIL: pll_reset=0, sys_reset=1, fail=1. FAIL is left only by reset.
REQ-030 psda SHALL be preserved across PLL resets; only reset clears it.
REQ-031 phase_req with phase_val equal to the current psda SHALL still complete a full settle and ack.

Reset
REQ-032 On reset: state=PLLRST with counter loaded to RST_CYCLES, pll_reset=1, sys_reset=1, psda=0, phase_ack=0, locked=0, fail=0, retry_cnt=0, synchronizer flops=0.
REQ-033 Reset asserted in any state, including PHASE or FAIL, SHALL take effect on the next clk edge and restart the sequence.

Structure
REQ-034 Package pll_supervisor_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-035 The synchronizer SHALL be a separate sub-module, pll_lock_sync (2-flop, reset to 0).

Verification
REQ-036 All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRY=2, PHASE_SETTLE_CYCLES=4.
REQ-037 Nominal bring-up: reset, then pll_lock=1 from cycle 6 -> pll_reset high for exactly 4 cycles; sys_reset falls and locked rises 2+8 cycles after lock rises.
REQ-038 No lock: pll_lock stuck at 0 -> two 4-cycle pll_reset pulses spaced 32 cycles apart; then fail=1, retry_cnt=2, sys_reset=1, and the FAIL state is held.
REQ-039 Lock glitch in STABLE: pll_lock low for 1 cycle at stable count 5 -> retry_cnt=1, new pll_reset pulse, then successful RUN entry with retry_cnt=0.
REQ-040 Phase change: phase_req=1, phase_val=4'hA in RUN -> psda=4'hA next cycle; phase_ack is a single pulse 4 cycles later; sys_reset stays 0 throughout.
REQ-041 Lock loss during PHASE: pll_lock dropped 2 cycles into settle -> no ack, sys_reset=1, psda stays 4'hA; after re-lock, the ack is issued for the still-held request.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL supervisor: state encoding, default timing
// constants and the counter-width helper.
package pll_supervisor_pkg;

    localparam int unsigned DEF_RST_CYCLES          = 8;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_MAX_RETRY           = 4;
    localparam int unsigned DEF_PHASE_SETTLE_CYCLES = 16;

    localparam int unsigned PHASE_W = 4;
    localparam int unsigned RETRY_W = 3;

    typedef enum logic [2:0] {
        ST_PLLRST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_PHASE,
        ST_FAIL
    } state_t;

    // Width of the shared down-counter, large enough for the longest interval.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous rPLL LOCK into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic lock_raw,
    output logic lock_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            meta      <= lock_raw;
            lock_sync <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// rPLL bring-up supervisor: reset pulse, lock qualification with retries,
// system reset release and dynamic phase-select handshaking.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY           = DEF_MAX_RETRY,
    parameter int unsigned PHASE_SETTLE_CYCLES = DEF_PHASE_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [PHASE_W-1:0] psda,
    input  logic               phase_req,
    input  logic [PHASE_W-1:0] phase_val,
    output logic               phase_ack,
    output logic               sys_reset,
    output logic               locked,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES, PHASE_SETTLE_CYCLES);

    logic               lk;
    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [RETRY_W-1:0] retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic [PHASE_W-1:0] psda_next;
    logic               ack_next;
    logic               attempt_failed;
    logic               active_next;

    pll_lock_sync u_lock_sync (
        .clk       (clk),
        .reset     (reset),
        .lock_raw  (pll_lock),
        .lock_sync (lk)
    );

    // Next-state, counter, retry and phase-select logic.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        retry_next     = retry_cnt;
        psda_next      = psda;
        ack_next       = 1'b0;
        attempt_failed = 1'b0;
        retry_inc      = retry_cnt + RETRY_W'(1);

        case (state)
            ST_PLLRST: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = CNT_W'(LOCK_TIMEOUT_CYCLES);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_next = ST_STABLE;
                    cnt_next   = CNT_W'(LOCK_STABLE_CYCLES);
                end else if (cnt == CNT_W'(1)) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lk) begin
                    attempt_failed = 1'b1;
                end else if (cnt == CNT_W'(1)) begin
                    state_next = ST_RUN;
                    retry_next = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_next = ST_PLLRST;
                    cnt_next   = CNT_W'(RST_CYCLES);
                end else if (phase_req) begin
                    state_next = ST_PHASE;
                    psda_next  = phase_val;
                    cnt_next   = CNT_W'(PHASE_SETTLE_CYCLES);
                end
            end
            ST_PHASE: begin
                // Count reaches zero on the ack cycle; the following cycle returns to RUN.
                if (!lk) begin
                    state_next = ST_PLLRST;
                    cnt_next   = CNT_W'(RST_CYCLES);
                end else if (cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                    ack_next = (cnt == CNT_W'(1));
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_PLLRST;
                cnt_next   = CNT_W'(RST_CYCLES);
            end
        endcase

        if (attempt_failed) begin
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_PLLRST;
            cnt_next   = CNT_W'(RST_CYCLES);
        end

        active_next = (state_next == ST_RUN) || (state_next == ST_PHASE);
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PLLRST;
            cnt       <= CNT_W'(RST_CYCLES);
            retry_cnt <= '0;
            psda      <= '0;
            phase_ack <= 1'b0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            retry_cnt <= retry_next;
            psda      <= psda_next;
            phase_ack <= ack_next;
            pll_reset <= (state_next == ST_PLLRST);
            sys_reset <= !active_next;
            locked    <= active_next;
            fail      <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// Scenario bench for pll_supervisor; expected event times come from the
// documented timing rules (sync latency, pulse and settle lengths).
module tb_pll_supervisor;

    localparam int RST    = 4;
    localparam int STB    = 8;
    localparam int TMO    = 32;
    localparam int MAXR   = 2;
    localparam int SETTLE = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       phase_req;
    logic [3:0] phase_val;
    logic       pll_reset;
    logic [3:0] psda;
    logic       phase_ack;
    logic       sys_reset;
    logic       locked;
    logic       fail;
    logic [2:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pll_supervisor #(
        .RST_CYCLES          (RST),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRY           (MAXR),
        .PHASE_SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .psda      (psda),
        .phase_req (phase_req),
        .phase_val (phase_val),
        .phase_ack (phase_ack),
        .sys_reset (sys_reset),
        .locked    (locked),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    // An input driven at negedge index d is first seen by the state logic d+1+SYNC.
    function automatic int seen_at(input int d);
        return d + 1 + SYNC;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        pll_lock  = 1'b0;
        phase_req = 1'b0;
        phase_val = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic get_to_run(input int k);
        int n;
        n = 0;
        apply_reset();
        while (sys_reset === 1'b1 && n < 80) begin
            if (cyc == k) pll_lock = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (sys_reset !== 1'b0) begin
            errors++;
            $display("FAIL get_to_run: sys_reset=%b after %0d cycles, required 0", sys_reset, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_lock = 1'b1; phase_req = 1'b0; phase_val = 4'h0;
        repeat (2) tick();
        checks += 7;
        if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
        if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys_reset: got %b want 1", sys_reset); end
        if (psda !== 4'h0)      begin errors++; $display("FAIL reset_psda: got %h want 0", psda); end
        if (phase_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", phase_ack); end
        if (locked !== 1'b0)    begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (fail !== 1'b0)      begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
        if (retry_cnt !== 3'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_bringup(input int k);
        int rst_hi, rel, lk_at_rel, retry_at_rel;
        rst_hi = 0; rel = -1; lk_at_rel = 0; retry_at_rel = 7;
        apply_reset();
        for (int i = 0; i < 60 && rel < 0; i++) begin
            if (cyc == k) pll_lock = 1'b1;
            if (pll_reset === 1'b1) rst_hi++;
            if (sys_reset === 1'b0) begin
                rel = cyc; lk_at_rel = int'(locked); retry_at_rel = int'(retry_cnt);
            end
            tick();
        end
        checks += 4;
        if (rst_hi != RST) begin errors++; $display("FAIL bringup_pulse_len: got %0d want %0d", rst_hi, RST); end
        if (rel != seen_at(k) + STB) begin errors++; $display("FAIL bringup_release: got %0d want %0d", rel, seen_at(k) + STB); end
        if (lk_at_rel != 1) begin errors++; $display("FAIL bringup_locked: got %0d want 1", lk_at_rel); end
        if (retry_at_rel != 0) begin errors++; $display("FAIL bringup_retry: got %0d want 0", retry_at_rel); end
    endtask

    task automatic test_no_lock();
        int starts[$];
        int hi, fail_at, bad_hold, prev;
        hi = 0; fail_at = -1; bad_hold = 0; prev = 0;
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            if (pll_reset === 1'b1 && prev == 0) starts.push_back(cyc);
            if (pll_reset === 1'b1) hi++;
            if (fail === 1'b1 && fail_at < 0) fail_at = cyc;
            if (fail_at >= 0 && (fail !== 1'b1 || pll_reset !== 1'b0 || sys_reset !== 1'b1 || locked !== 1'b0))
                bad_hold++;
            prev = int'(pll_reset);
            tick();
        end
        checks += 5;
        if (starts.size() != MAXR) begin errors++; $display("FAIL nolock_pulses: got %0d want %0d", starts.size(), MAXR); end
        else if (starts[1] - starts[0] != RST + TMO) begin
            errors++; $display("FAIL nolock_spacing: got %0d want %0d", starts[1] - starts[0], RST + TMO);
        end
        if (hi != MAXR * RST) begin errors++; $display("FAIL nolock_high_cycles: got %0d want %0d", hi, MAXR * RST); end
        if (fail_at != MAXR * (RST + TMO)) begin errors++; $display("FAIL nolock_fail_time: got %0d want %0d", fail_at, MAXR * (RST + TMO)); end
        if (retry_cnt !== 3'(MAXR)) begin errors++; $display("FAIL nolock_retry: got %0d want %0d", retry_cnt, MAXR); end
        if (bad_hold != 0) begin errors++; $display("FAIL nolock_hold: %0d bad cycles, want 0", bad_hold); end
        // Reset must leave FAIL on the next edge.
        reset = 1'b1;
        tick();
        checks += 3;
        if (fail !== 1'b0)      begin errors++; $display("FAIL failreset_fail: got %b want 0", fail); end
        if (pll_reset !== 1'b1) begin errors++; $display("FAIL failreset_pll_reset: got %b want 1", pll_reset); end
        if (retry_cnt !== 3'd0) begin errors++; $display("FAIL failreset_retry: got %0d want 0", retry_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_glitch(input int j);
        int p2_start, p2_len, r1, rel, retry_at_rel, f;
        p2_start = -1; p2_len = 0; r1 = -1; rel = -1; retry_at_rel = 7;
        apply_reset();
        for (int i = 0; i < 60 && rel < 0; i++) begin
            if (cyc == 5) pll_lock = 1'b1;
            if (cyc == j) pll_lock = 1'b0;
            if (cyc == j + 1) pll_lock = 1'b1;
            if (pll_reset === 1'b1 && cyc >= RST) begin
                if (p2_start < 0) p2_start = cyc;
                p2_len++;
            end
            if (retry_cnt === 3'd1 && r1 < 0) r1 = cyc;
            if (sys_reset === 1'b0) begin rel = cyc; retry_at_rel = int'(retry_cnt); end
            tick();
        end
        f = seen_at(j);
        checks += 5;
        if (r1 != f) begin errors++; $display("FAIL glitch_retry_time: got %0d want %0d", r1, f); end
        if (p2_start != f) begin errors++; $display("FAIL glitch_pulse_start: got %0d want %0d", p2_start, f); end
        if (p2_len != RST) begin errors++; $display("FAIL glitch_pulse_len: got %0d want %0d", p2_len, RST); end
        if (rel != f + RST + 1 + STB) begin errors++; $display("FAIL glitch_release: got %0d want %0d", rel, f + RST + 1 + STB); end
        if (retry_at_rel != 0) begin errors++; $display("FAIL glitch_retry_clear: got %0d want 0", retry_at_rel); end
    endtask

    task automatic test_phase(input logic [3:0] val);
        int m, acks, ack_at, sys_hi;
        logic [3:0] psda_after;
        acks = 0; ack_at = -1; sys_hi = 0; psda_after = 4'h0;
        m = cyc;
        phase_req = 1'b1;
        phase_val = val;
        for (int i = 0; i < 20; i++) begin
            if (cyc == m + 1) psda_after = psda;
            if (phase_ack === 1'b1) begin acks++; if (ack_at < 0) ack_at = cyc; end
            if (sys_reset !== 1'b0 || locked !== 1'b1) sys_hi++;
            if (ack_at >= 0 && cyc == ack_at + 1) phase_req = 1'b0;
            tick();
        end
        phase_req = 1'b0;
        checks += 4;
        if (psda_after !== val) begin errors++; $display("FAIL phase_psda: got %h want %h", psda_after, val); end
        if (ack_at != m + 1 + SETTLE) begin errors++; $display("FAIL phase_ack_time: got %0d want %0d", ack_at, m + 1 + SETTLE); end
        if (acks != 1) begin errors++; $display("FAIL phase_ack_count: got %0d want 1", acks); end
        if (sys_hi != 0) begin errors++; $display("FAIL phase_sys_reset: %0d cycles not in run, want 0", sys_hi); end
    endtask

    task automatic test_run_loss();
        int d, sh, ph, bad_retry;
        sh = -1; ph = -1; bad_retry = 0;
        d = cyc;
        pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sys_reset === 1'b1 && sh < 0) sh = cyc;
            if (pll_reset === 1'b1 && ph < 0) ph = cyc;
            if (retry_cnt !== 3'd0) bad_retry++;
            tick();
        end
        checks += 3;
        if (sh != seen_at(d)) begin errors++; $display("FAIL runloss_sys_reset: got %0d want %0d", sh, seen_at(d)); end
        if (ph != seen_at(d)) begin errors++; $display("FAIL runloss_pll_reset: got %0d want %0d", ph, seen_at(d)); end
        if (bad_retry != 0) begin errors++; $display("FAIL runloss_retry: %0d nonzero cycles, want 0", bad_retry); end
    endtask

    task automatic test_phase_loss(input int extra);
        int m, r, sh, rel, acks, ack_at, bad_psda;
        sh = -1; rel = -1; acks = 0; ack_at = -1; bad_psda = 0;
        get_to_run(5);
        m = cyc;
        r = m + 8 + extra;
        phase_req = 1'b1;
        phase_val = 4'hA;
        for (int i = 0; i < 50; i++) begin
            if (cyc == m + 1) pll_lock = 1'b0;
            if (cyc == r) pll_lock = 1'b1;
            if (cyc > m && psda !== 4'hA) bad_psda++;
            if (sys_reset === 1'b1 && sh < 0) sh = cyc;
            if (sh >= 0 && rel < 0 && sys_reset === 1'b0) rel = cyc;
            if (phase_ack === 1'b1) begin acks++; if (ack_at < 0) ack_at = cyc; end
            if (ack_at >= 0 && cyc == ack_at + 1) phase_req = 1'b0;
            tick();
        end
        phase_req = 1'b0;
        checks += 5;
        if (sh != seen_at(m + 1)) begin errors++; $display("FAIL phaseloss_sys_reset: got %0d want %0d", sh, seen_at(m + 1)); end
        if (bad_psda != 0) begin errors++; $display("FAIL phaseloss_psda: %0d cycles not A, want 0", bad_psda); end
        if (rel != seen_at(r) + STB) begin errors++; $display("FAIL phaseloss_release: got %0d want %0d", rel, seen_at(r) + STB); end
        if (acks != 1) begin errors++; $display("FAIL phaseloss_ack_count: got %0d want 1", acks); end
        if (ack_at != rel + 1 + SETTLE) begin errors++; $display("FAIL phaseloss_ack_time: got %0d want %0d", ack_at, rel + 1 + SETTLE); end
    endtask

    task automatic test_reset_in_phase();
        get_to_run(6);
        phase_req = 1'b1;
        phase_val = 4'h5;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks += 4;
        if (psda !== 4'h0)      begin errors++; $display("FAIL phasereset_psda: got %h want 0", psda); end
        if (locked !== 1'b0)    begin errors++; $display("FAIL phasereset_locked: got %b want 0", locked); end
        if (sys_reset !== 1'b1) begin errors++; $display("FAIL phasereset_sys_reset: got %b want 1", sys_reset); end
        if (pll_reset !== 1'b1) begin errors++; $display("FAIL phasereset_pll_reset: got %b want 1", pll_reset); end
        reset = 1'b0;
        phase_req = 1'b0;
    endtask

    initial begin
        logic [3:0] v;
        test_reset();
        test_bringup(5);
        for (int i = 0; i < 3; i++) test_bringup(int'($urandom_range(5, 25)));
        test_no_lock();
        test_glitch(10);
        test_glitch(int'($urandom_range(6, 12)));
        get_to_run(5);
        test_phase(4'hA);
        test_phase(4'hA);
        v = 4'($urandom_range(0, 15));
        test_phase(v);
        test_run_loss();
        test_phase_loss(int'($urandom_range(0, 5)));
        test_reset_in_phase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
